// File: rtl/score_renderer.sv
// Draws the 3-digit score into the framebuffer: latches the score, captures the
// glyph bitmap from score_to_display, then streams 90 pixel writes over valid/ready.
module score_renderer #(
    parameter int         X_ORIGIN    = 0,
    parameter int         Y_ORIGIN    = 0,
    parameter int         DIGIT_PITCH = 6,
    parameter logic [2:0] FG_COLOUR   = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter bit         BLANK_LZ    = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  score,
    input  logic        update,
    output logic [7:0]  disp_score,
    input  logic [89:0] disp_bitmap,
    output logic [7:0]  plot_x,
    output logic [6:0]  plot_y,
    output logic [2:0]  plot_colour,
    output logic        plot_valid,
    input  logic        plot_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, LATCH, CAPTURE, DRAW, DONE} state_t;

    state_t      state, state_next;
    logic        pending;
    logic [89:0] bitmap;
    logic        blank_h, blank_t;
    logic [1:0]  digit;
    logic [2:0]  row, col;
    logic        xfer, last_pixel, glyph_bit, digit_blank;
    logic [6:0]  bit_idx;

    assign xfer        = (state == DRAW) && plot_ready;
    assign last_pixel  = (digit == 2'd0) && (row == 3'd4) && (col == 3'd5);
    assign bit_idx     = 7'(30 * int'(digit) + 6 * int'(row) + 5 - int'(col));
    assign glyph_bit   = bitmap[bit_idx];
    assign digit_blank = ((digit == 2'd2) && blank_h) || ((digit == 2'd1) && blank_t);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        plot_valid  = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = '0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE:    if (update || pending) state_next = LATCH;
            LATCH:   state_next = CAPTURE;
            CAPTURE: state_next = DRAW;
            DRAW: begin
                plot_valid  = 1'b1;
                plot_x      = 8'(X_ORIGIN + (2 - int'(digit)) * DIGIT_PITCH + int'(col));
                plot_y      = 7'(Y_ORIGIN + int'(row));
                plot_colour = (glyph_bit && !digit_blank) ? FG_COLOUR : BG_COLOUR;
                if (xfer && last_pixel) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = pending ? LATCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            disp_score <= '0;
            bitmap     <= '0;
            blank_h    <= 1'b0;
            blank_t    <= 1'b0;
            digit      <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            state <= state_next;

            // A redraw that starts consumes the request; any update while busy queues one more.
            if (state_next == LATCH)
                pending <= 1'b0;
            else if (state != IDLE && update)
                pending <= 1'b1;

            if (state == LATCH)
                disp_score <= score;

            if (state == CAPTURE) begin
                bitmap  <= disp_bitmap;
                // Hundreds is zero iff score < 100; hundreds and tens both zero iff score < 10.
                blank_h <= BLANK_LZ && (disp_score < 8'd100);
                blank_t <= BLANK_LZ && (disp_score < 8'd10);
                digit   <= 2'd2;
                row     <= 3'd0;
                col     <= 3'd0;
            end else if (xfer) begin
                if (col == 3'd5) begin
                    col <= 3'd0;
                    if (row == 3'd4) begin
                        row <= 3'd0;
                        if (digit != 2'd0) digit <= digit - 2'd1;
                    end else begin
                        row <= row + 3'd1;
                    end
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer: a local glyph font stands in for
// score_to_display; table-driven redraws plus sequences for update-while-busy and reset.
module tb_score_renderer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  score_in = 8'd0;
    logic        plot_ready = 1'b1;
    logic        upd [2];
    logic [7:0]  ds  [2];
    logic [89:0] bm  [2];
    logic [7:0]  px  [2];
    logic [6:0]  py  [2];
    logic [2:0]  pc  [2];
    logic        pv  [2];
    logic        bsy [2];
    logic        dn  [2];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    function automatic logic [29:0] glyph(input int v);
        // {row4, row3, row2, row1, row0}; column 0 is the MSB of each row
        case (v)
            0: glyph = {6'b011100, 6'b100010, 6'b100010, 6'b100010, 6'b011100};
            1: glyph = {6'b011100, 6'b001000, 6'b001000, 6'b011000, 6'b001000};
            2: glyph = {6'b111110, 6'b100000, 6'b011100, 6'b000010, 6'b111100};
            3: glyph = {6'b111100, 6'b000010, 6'b011100, 6'b000010, 6'b111100};
            4: glyph = {6'b000100, 6'b000100, 6'b111110, 6'b100100, 6'b100100};
            5: glyph = {6'b111000, 6'b000100, 6'b111000, 6'b100000, 6'b111110};
            6: glyph = {6'b011100, 6'b100010, 6'b111100, 6'b100000, 6'b011100};
            7: glyph = {6'b001000, 6'b001000, 6'b000100, 6'b000010, 6'b111110};
            8: glyph = {6'b011100, 6'b100010, 6'b011100, 6'b100010, 6'b011100};
            9: glyph = {6'b011100, 6'b000010, 6'b011110, 6'b100010, 6'b011100};
            default: glyph = '0;
        endcase
    endfunction

    function automatic logic [89:0] font_bitmap(input logic [7:0] s);
        return {glyph(int'(s) / 100), glyph((int'(s) / 10) % 10), glyph(int'(s) % 10)};
    endfunction

    function automatic logic [2:0] exp_colour(input int s, input bit blz, input int i);
        int d, r, c, v;
        bit blank;
        logic [29:0] g;
        d = 2 - i / 30;
        r = (i % 30) / 6;
        c = i % 6;
        v = (d == 2) ? s / 100 : (d == 1) ? (s / 10) % 10 : s % 10;
        blank = blz && ((d == 2 && s / 100 == 0) ||
                        (d == 1 && s / 100 == 0 && (s / 10) % 10 == 0));
        g = glyph(v);
        return (!blank && g[6 * r + 5 - c]) ? 3'b111 : 3'b000;
    endfunction

    assign bm[0] = font_bitmap(ds[0]);
    assign bm[1] = font_bitmap(ds[1]);

    score_renderer #(.BLANK_LZ(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .score(score_in), .update(upd[0]),
        .disp_score(ds[0]), .disp_bitmap(bm[0]),
        .plot_x(px[0]), .plot_y(py[0]), .plot_colour(pc[0]),
        .plot_valid(pv[0]), .plot_ready(plot_ready), .busy(bsy[0]), .done(dn[0])
    );

    score_renderer #(.BLANK_LZ(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .score(score_in), .update(upd[1]),
        .disp_score(ds[1]), .disp_bitmap(bm[1]),
        .plot_x(px[1]), .plot_y(py[1]), .plot_colour(pc[1]),
        .plot_valid(pv[1]), .plot_ready(plot_ready), .busy(bsy[1]), .done(dn[1])
    );

    // transfer log and per-run observations
    logic [7:0] tx   [300];
    logic [6:0] ty   [300];
    logic [2:0] tcol [300];
    int         tcyc [300];
    int         done_cyc [8];
    int n, done_n, busy_first, busy_last, stall_bad, cyc;
    bit rand_ready;
    bit prev_stall;
    logic [7:0] prev_x;
    logic [6:0] prev_y;
    logic [2:0] prev_c;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n = 0;
        done_n = 0;
        busy_first = -1;
        busy_last = -1;
        stall_bad = 0;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
    task automatic step(input int inst, input logic u);
        @(negedge clock);
        upd[inst] = u;
        plot_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cyc++;
        if (prev_stall && (!pv[inst] || px[inst] != prev_x || py[inst] != prev_y || pc[inst] != prev_c))
            stall_bad++;
        prev_stall = pv[inst] && !plot_ready;
        prev_x = px[inst];
        prev_y = py[inst];
        prev_c = pc[inst];
        if (pv[inst] && plot_ready && n < 300) begin
            tx[n] = px[inst];
            ty[n] = py[inst];
            tcol[n] = pc[inst];
            tcyc[n] = cyc;
            n++;
        end
        if (bsy[inst]) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (dn[inst]) begin
            if (done_n < 8) done_cyc[done_n] = cyc;
            done_n++;
        end
    endtask

    task automatic count_pixels(input int s, input bit blz, input int base,
                                output int bad_px, output int fg_all, output int fg_units);
        bad_px = 0;
        fg_all = 0;
        fg_units = 0;
        for (int i = 0; i < 90; i++) begin
            if (tx[base + i] !== 8'((i / 30) * 6 + i % 6) ||
                ty[base + i] !== 7'((i % 30) / 6) ||
                tcol[base + i] !== exp_colour(s, blz, i))
                bad_px++;
            if (tcol[base + i] == 3'b111) begin
                fg_all++;
                if (i >= 60) fg_units++;
            end
        end
    endtask

    task automatic run_draw(input int s, input bit inst, input bit rr,
                            input int exp_fg, input int exp_units);
        int n0, t, bad_px, fg, fu;
        clear_stats();
        rand_ready = rr;
        score_in = 8'(s);
        step(int'(inst), 1'b1);
        n0 = cyc;
        t = 0;
        while (done_n == 0 && t < 2000) begin
            step(int'(inst), 1'b0);
            t++;
        end
        repeat (3) step(int'(inst), 1'b0);
        check($sformatf("done_count s=%0d", s), done_n, 1);
        check($sformatf("xfers s=%0d", s), n, 90);
        count_pixels(s, inst, 0, bad_px, fg, fu);
        check($sformatf("pixel_errs s=%0d", s), bad_px, 0);
        check($sformatf("fg_total s=%0d", s), fg, exp_fg);
        check($sformatf("fg_units s=%0d", s), fu, exp_units);
        if (!rr) begin
            check($sformatf("first_xfer s=%0d", s), tcyc[0], n0 + 3);
            check($sformatf("last_xfer s=%0d", s), tcyc[89], n0 + 92);
            check($sformatf("done_cycle s=%0d", s), done_cyc[0], n0 + 93);
            check($sformatf("busy_first s=%0d", s), busy_first, n0 + 1);
            check($sformatf("busy_last s=%0d", s), busy_last, n0 + 93);
        end else begin
            check($sformatf("stall_hold s=%0d", s), stall_bad, 0);
        end
        rand_ready = 1'b0;
        score_in = ~score_in;
        repeat (2) step(int'(inst), 1'b0);
        check($sformatf("disp_hold s=%0d", s), int'(ds[inst]), s);
    endtask

    typedef struct {
        int score;
        bit blank;
        bit rnd;
        int fg;
        int units;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t, bad_px, fg, fu, pre_valid;

        // score, blank instance, random ready, FG total, FG in units digit
        vecs[0] = '{0,   1'b0, 1'b0, 36, 12};
        vecs[1] = '{255, 1'b0, 1'b0, 40, 13};
        vecs[2] = '{128, 1'b0, 1'b1, 35, 13};
        vecs[3] = '{5,   1'b1, 1'b0, 13, 13};
        vecs[4] = '{105, 1'b1, 1'b0, 33, 13};
        vecs[5] = '{30,  1'b1, 1'b1, 25, 12};
        vecs[6] = '{5,   1'b0, 1'b0, 37, 13};
        vecs[7] = '{100, 1'b1, 1'b0, 32, 12};

        upd[0] = 1'b0;
        upd[1] = 1'b0;
        rand_ready = 1'b0;
        cyc = 0;
        clear_stats();

        repeat (3) @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid%0d", k), int'(pv[k]), 0);
            check($sformatf("rst_busy%0d", k), int'(bsy[k]), 0);
            check($sformatf("rst_done%0d", k), int'(dn[k]), 0);
            check($sformatf("rst_disp%0d", k), int'(ds[k]), 0);
            check($sformatf("rst_xyc%0d", k), int'({px[k], py[k], pc[k]}), 0);
        end
        @(negedge clock);
        reset = 1'b0;

        for (int v = 0; v < 8; v++)
            run_draw(vecs[v].score, vecs[v].blank, vecs[v].rnd, vecs[v].fg, vecs[v].units);

        // first transfer of an all-zero score is the top-left background pixel
        run_draw(0, 1'b0, 1'b0, 36, 12);
        check("zero_first_pixel", int'({tx[0], ty[0], tcol[0]}), 0);

        // updates during DRAW queue exactly one follow-up redraw of the newest score
        clear_stats();
        score_in = 8'd7;
        step(0, 1'b1);
        t = 0;
        while (n < 20 && t < 300) begin
            step(0, 1'b0);
            t++;
        end
        score_in = 8'd42;
        step(0, 1'b1);
        repeat (5) step(0, 1'b0);
        step(0, 1'b1);
        t = 0;
        while (done_n < 2 && t < 1000) begin
            step(0, 1'b0);
            t++;
        end
        repeat (150) step(0, 1'b0);
        check("busy_done_count", done_n, 2);
        check("busy_xfers", n, 180);
        count_pixels(7, 1'b0, 0, bad_px, fg, fu);
        check("busy_pass1_pixels", bad_px, 0);
        count_pixels(42, 1'b0, 90, bad_px, fg, fu);
        check("busy_pass2_pixels", bad_px, 0);
        check("busy_pass_gap", done_cyc[1] - done_cyc[0], 93);
        check("busy_disp_score", int'(ds[0]), 42);

        // reset asserted while the 40th transfer is being offered
        clear_stats();
        score_in = 8'd88;
        step(0, 1'b1);
        t = 0;
        while (n < 40 && t < 300) begin
            step(0, 1'b0);
            t++;
        end
        pre_valid = int'(pv[0]);
        check("rst_mid_pre_valid", pre_valid, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", int'(pv[0]), 0);
        check("rst_mid_busy", int'(bsy[0]), 0);
        check("rst_mid_done", int'(dn[0]), 0);
        @(negedge clock);
        reset = 1'b0;
        clear_stats();
        repeat (120) step(0, 1'b0);
        check("post_rst_xfers", n, 0);
        check("post_rst_busy", busy_first, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_renderer.md
Name: score_renderer

Overview:
Sequential controller that draws the 3-digit score onto the VGA framebuffer. It drives the score value into the existing combinational score_to_display block and captures the 90-bit glyph bitmap that block returns. It then streams one pixel write per bitmap bit to the framebuffer plotter over a valid/ready handshake. It sits between the game-logic score register and the shared framebuffer write port.

Parameters:
X_ORIGIN, 0, screen x of the leftmost column of the hundreds digit
Y_ORIGIN, 0, screen y of the top row
DIGIT_PITCH, 6, x distance between the left edges of adjacent digits (must be >= 6)
FG_COLOUR, 3'b111, colour for a set glyph bit
BG_COLOUR, 3'b000, colour for a clear glyph bit
BLANK_LZ, 0, 1 = draw leading-zero digits entirely in BG_COLOUR

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
score  input  8  current game score
update  input  1  redraw request, sampled each clock
disp_score  output  8  score driven to score_to_display
disp_bitmap  input  90  glyph bitmap returned by score_to_display
plot_x  output  8  pixel x
plot_y  output  7  pixel y
plot_colour  output  3  pixel colour
plot_valid  output  1  pixel write request
plot_ready  input  1  plotter accepts the write
busy  output  1  high from LATCH through DONE inclusive
done  output  1  one-cycle pulse when a redraw completes

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- Reset values: every output is 0, state is IDLE, pending is cleared, all counters are 0. Asserting reset mid-draw drops plot_valid immediately. Nothing resumes after reset is released.
- Bitmap layout: digit k (2 = hundreds, 1 = tens, 0 = units) occupies bits [30k+29:30k]. Row r (0 = top, 0..4) within a digit occupies bits [6r+5:6r]. Column c (0 = leftmost, 0..5) is bit 5-c of that row.
- State machine:
  - IDLE: update=1 -> LATCH.
  - LATCH: disp_score <= score. Next state CAPTURE.
  - CAPTURE: register disp_bitmap, then compute the blanking masks. Hundreds digit is blank if BLANK_LZ and hundreds value = 0. Tens digit is blank if BLANK_LZ and hundreds = 0 and tens = 0. The units digit is never blanked. Digit values are derived from the latched disp_score. Load digit=2, row=0, col=0. Next state DRAW.
  - DRAW: plot_valid=1.
    - plot_x = X_ORIGIN + (2-digit)*DIGIT_PITCH + col.
    - plot_y = Y_ORIGIN + row.
    - plot_colour = FG_COLOUR if the bit is set and the digit is not blanked, else BG_COLOUR.
    - A transfer occurs on any cycle with plot_valid && plot_ready.
    - Between transfers, plot_x, plot_y and plot_colour are held stable.
    - Scan order: col increments fastest, then row, then digit runs 2 down to 0.
    - The transfer of pixel (digit 0, row 4, col 5) -> DONE, with plot_valid low in the next cycle.
  - DONE: done=1 for exactly one cycle. Next state is LATCH if pending=1 (pending is cleared), else IDLE.
- Update while busy: an update seen in LATCH, CAPTURE, DRAW or DONE sets pending. Multiple updates collapse into one. The follow-up redraw samples score at its own LATCH, so the newest value is drawn.
- Exactly 90 transfers per redraw.
- Latency with plot_ready tied high (update at cycle N):
  - LATCH at N+1, CAPTURE at N+2.
  - First plot_valid at N+3; transfers occur at N+3..N+92.
  - done at N+93; IDLE at N+94.
- Coordinate arithmetic is modulo 2^8 for x and 2^7 for y. No clipping.
- disp_score holds its last value between redraws.

Test Plan:
- BLANK_LZ=0, score=0, update pulse, plot_ready=1 -> 90 transfers at cycles N+3..N+92; first transfer x=0, y=0, colour 000; FG count 36, BG count 54; done only at N+93; busy high N+1..N+93.
- score=255, plot_ready=1 -> rendered pixels match the glyphs for 2, 5, 5. Hundreds glyph occupies x 0..5, tens x 6..11, units x 12..17, y 0..4.
- Backpressure: plot_ready pseudo-random at 50% -> still exactly 90 transfers, in scan order. plot_x, plot_y, plot_colour are unchanged across every cycle with valid=1 and ready=0.
- Update while busy: score=7 with update, then score=42 with two update pulses during DRAW -> first pass draws 007 and pulses done. The second pass starts at the next cycle (LATCH), draws 042, and pulses done. There is no third pass.
- BLANK_LZ=1, score=5 -> the first 60 transfers are BG_COLOUR and the units digit has 13 FG pixels. With score=105, the tens digit is drawn (it is not blanked).
- Assert reset at the 40th transfer -> plot_valid, busy and done are 0 in the same cycle. After release with no update, the block stays IDLE with no further transfers.
